hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_ctrl_sat_counter.sv | 23 ++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared hazard-control definitions: FSM state encoding, default memory timeout
// and the load-use hazard predicate.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    HALT    = 2'b10
  } hz_state_t;

  localparam int MEM_TIMEOUT_DEF = 64;

  // A load in EX feeds a source the ID instruction actually reads; r0 is never a hazard.
  function automatic logic load_use(
    input logic       re_mem,
    input logic       we_rf,
    input logic [3:0] dst,
    input logic [3:0] p0,
    input logic [3:0] p1,
    input logic       p0_used,
    input logic       p1_used
  );
    return re_mem && we_rf && (dst != 4'h0) &&
           ((p0_used && (dst == p0)) || (p1_used && (dst == p1)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts inc cycles and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (inc && (q_reg != {W{1'b1}})) begin
      q_reg <= q_reg + 1'b1;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout, branch flush,
// load-use stall, halt, and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re_mem_EX,
  input  logic             we_rf_EX,
  input  logic [3:0]       dst_addr_EX,
  input  logic [3:0]       p0_addr_ID,
  input  logic [3:0]       p1_addr_ID,
  input  logic             p0_used_ID,
  input  logic             p1_used_ID,
  input  logic             branch_taken_EX,
  input  logic             mem_busy,
  input  logic             hlt_WB,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_MEM,
  output logic             stall_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              halted_reg, err_reg;
  logic              freeze, run_rules, timeout, lu_hit;
  logic [6:0]        ctl;  // {stall PC..MEM_WB, flush IF_ID, flush ID_EX}

  assign lu_hit = load_use(re_mem_EX, we_rf_EX, dst_addr_EX, p0_addr_ID, p1_addr_ID,
                           p0_used_ID, p1_used_ID);

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    freeze        = 1'b0;
    run_rules     = 1'b0;
    timeout       = 1'b0;
    ctl           = 7'b0;
    unique case (state_reg)
      RUN: begin
        if (mem_busy) begin
          freeze        = 1'b1;
          state_next    = MEMWAIT;
          // The entry cycle already counts as one busy cycle toward the timeout.
          wait_cnt_next = WAIT_W'(1);
        end else begin
          run_rules = 1'b1;
        end
      end
      MEMWAIT: begin
        if (mem_busy) begin
          freeze = 1'b1;
          if (wait_cnt_reg >= WAIT_LAST) begin
            timeout    = 1'b1;
            state_next = HALT;
          end else begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
          end
        end else begin
          run_rules     = 1'b1;
          wait_cnt_next = '0;
          state_next    = RUN;
        end
      end
      HALT:    freeze = 1'b1;
      default: state_next = RUN;
    endcase

    if (freeze) begin
      ctl = 7'b11111_00;
    end else if (run_rules) begin
      if (branch_taken_EX) begin
        ctl = 7'b00000_11;
      end else if (lu_hit) begin
        ctl = 7'b11000_01;
      end
    end

    if (hlt_WB && (state_reg != HALT)) begin
      state_next = HALT;
    end
    if (rst) begin
      ctl = 7'b0;
    end
  end

  assign {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
          flush_IF_ID, flush_ID_EX} = ctl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      halted_reg   <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      halted_reg   <= halted_reg | (state_next == HALT);
      err_reg      <= err_reg | timeout;
    end
  end

  assign halted = halted_reg;
  assign err    = err_reg;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_PC),
    .q   (stall_cnt)
  );

  // Only a taken branch drives flush_IF_ID, so it marks exactly the branch flushes.
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_IF_ID),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int CW   = 4;
  localparam int TO   = 64;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          re_mem_EX, we_rf_EX, branch_taken_EX, mem_busy, hlt_WB;
  logic          p0_used_ID, p1_used_ID;
  logic [3:0]    dst_addr_EX, p0_addr_ID, p1_addr_ID;
  logic          stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic          flush_IF_ID, flush_ID_EX, halted, err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .re_mem_EX       (re_mem_EX),
    .we_rf_EX        (we_rf_EX),
    .dst_addr_EX     (dst_addr_EX),
    .p0_addr_ID      (p0_addr_ID),
    .p1_addr_ID      (p1_addr_ID),
    .p0_used_ID      (p0_used_ID),
    .p1_used_ID      (p1_used_ID),
    .branch_taken_EX (branch_taken_EX),
    .mem_busy        (mem_busy),
    .hlt_WB          (hlt_WB),
    .stall_PC        (stall_PC),
    .stall_IF_ID     (stall_IF_ID),
    .stall_ID_EX     (stall_ID_EX),
    .stall_EX_MEM    (stall_EX_MEM),
    .stall_MEM_WB    (stall_MEM_WB),
    .flush_IF_ID     (flush_IF_ID),
    .flush_ID_EX     (flush_ID_EX),
    .halted          (halted),
    .err             (err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;

  // Reference model: architectural view only (halted flag, consecutive busy run, counts).
  bit m_halt, m_err;
  int m_busy_run, m_scnt, m_fcnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  task automatic step(input bit r, input bit busy, input bit br, input bit hlt,
                      input bit re, input bit we, input logic [3:0] dst,
                      input logic [3:0] p0, input logic [3:0] p1,
                      input bit u0, input bit u1);
    bit lu, e_spc, e_sif, e_sie, e_sem, e_smw, e_fif, e_fie;
    @(negedge clk);
    rst = r; mem_busy = busy; branch_taken_EX = br; hlt_WB = hlt;
    re_mem_EX = re; we_rf_EX = we; dst_addr_EX = dst;
    p0_addr_ID = p0; p1_addr_ID = p1; p0_used_ID = u0; p1_used_ID = u1;
    #1;
    n_cyc++;
    lu = re && we && (dst != 0) && ((u0 && dst == p0) || (u1 && dst == p1));
    {e_spc, e_sif, e_sie, e_sem, e_smw, e_fif, e_fie} = '0;
    if (r) begin
      m_halt = 0; m_err = 0; m_busy_run = 0; m_scnt = 0; m_fcnt = 0;
    end else if (m_halt || busy) begin
      {e_spc, e_sif, e_sie, e_sem, e_smw} = 5'b11111;
    end else if (br) begin
      {e_fif, e_fie} = 2'b11;
    end else if (lu) begin
      {e_spc, e_sif, e_fie} = 3'b111;
    end
    check_eq("stall_PC",     stall_PC,     e_spc);
    check_eq("stall_IF_ID",  stall_IF_ID,  e_sif);
    check_eq("stall_ID_EX",  stall_ID_EX,  e_sie);
    check_eq("stall_EX_MEM", stall_EX_MEM, e_sem);
    check_eq("stall_MEM_WB", stall_MEM_WB, e_smw);
    check_eq("flush_IF_ID",  flush_IF_ID,  e_fif);
    check_eq("flush_ID_EX",  flush_ID_EX,  e_fie);
    check_eq("halted",       halted,       m_halt);
    check_eq("err",          err,          m_err);
    check_eq("stall_cnt",    stall_cnt,    m_scnt);
    check_eq("flush_cnt",    flush_cnt,    m_fcnt);
    $display("[TB] cyc=%0d rst=%0b busy=%0b br=%0b lu=%0b hlt=%0b -> stall=%b%b%b%b%b flush=%b%b halted=%0b err=%0b sc=%0d fc=%0d",
             n_cyc, r, busy, br, lu, hlt, stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
             stall_MEM_WB, flush_IF_ID, flush_ID_EX, halted, err, stall_cnt, flush_cnt);
    if (!r) begin
      if (e_spc) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
      if (e_fif) m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
      if (!m_halt) begin
        m_busy_run = busy ? m_busy_run + 1 : 0;
        if (m_busy_run >= TO) begin
          m_err  = 1;
          m_halt = 1;
        end
        if (hlt) m_halt = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
  endtask

  int burst_left;
  bit r_r, r_busy;

  initial begin
    rst = 1; mem_busy = 0; branch_taken_EX = 0; hlt_WB = 0;
    re_mem_EX = 0; we_rf_EX = 0; dst_addr_EX = 0;
    p0_addr_ID = 0; p1_addr_ID = 0; p0_used_ID = 0; p1_used_ID = 0;
    m_halt = 0; m_err = 0; m_busy_run = 0; m_scnt = 0; m_fcnt = 0;

    // Reset state
    do_reset();
    idle(2);

    // Load-use on p1: one stall cycle
    step(0, 0, 0, 0, 1, 1, 4'h3, 4'h5, 4'h3, 0, 1);
    idle(1);
    check_eq("lu_stall_cnt", stall_cnt, 1);

    // r0 destination and unused source produce no stall
    do_reset();
    step(0, 0, 0, 0, 1, 1, 4'h0, 4'h0, 4'h0, 1, 1);
    step(0, 0, 0, 0, 1, 1, 4'h7, 4'h7, 4'h2, 0, 0);
    idle(1);
    check_eq("no_lu_stall_cnt", stall_cnt, 0);

    // Branch beats concurrent load-use
    do_reset();
    step(0, 0, 1, 0, 1, 1, 4'h3, 4'h3, 4'h3, 1, 1);
    idle(1);
    check_eq("br_flush_cnt", flush_cnt, 1);
    check_eq("br_stall_cnt", stall_cnt, 0);

    // Memory wait of 5 cycles, RUN on the 6th
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    check_eq("mw_stall_cnt", stall_cnt, 5);
    check_eq("mw_run_no_stall", stall_PC, 0);

    // Timeout after 64 busy cycles, then reset clears everything
    do_reset();
    for (int i = 0; i < TO; i++) step(0, 1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    idle(2);
    check_eq("to_err", err, 1);
    check_eq("to_halted", halted, 1);
    do_reset();
    check_eq("to_rst_stall", stall_MEM_WB, 0);

    // Halt is sticky; stall counter saturates at all-ones
    do_reset();
    step(0, 0, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    idle(20);
    check_eq("halt_sticky", halted, 1);
    check_eq("halt_sat_cnt", stall_cnt, CMAX);

    // hlt_WB together with mem_busy still halts
    do_reset();
    step(0, 1, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0);
    idle(1);
    check_eq("hlt_busy_halted", halted, 1);

    // Randomized traffic
    do_reset();
    burst_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (burst_left == 0 && $urandom_range(0, 199) == 0) burst_left = $urandom_range(55, 70);
      r_r = ($urandom_range(0, 79) == 0);
      if (burst_left > 0) begin
        r_busy = 1;
        burst_left--;
      end else begin
        r_busy = ($urandom_range(0, 7) == 0);
      end
      step(r_r, r_busy, ($urandom_range(0, 5) == 0), ($urandom_range(0, 399) == 0),
           1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
